// File: rtl/tmcu_gpio_pkg.sv
// ----------------------------------------------------------------------------
// tmcu_gpio_pkg
// Shared constants and edge-mode decode for the GPIO controller and the
// register bank that programs it.
//   GPIO_MAX_WIDTH : largest supported pin count
//   GPIO_DEF_SYNC  : default input synchroniser depth
//   gpio_edge_e    : per-pin edge sensitivity, encoded as {fall_en, rise_en}
// ----------------------------------------------------------------------------
package tmcu_gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;
    localparam int GPIO_DEF_SYNC  = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } gpio_edge_e;

    // Pack the two enable bits into an edge mode; the bit order matches the enum encoding.
    function automatic gpio_edge_e edge_mode(input logic rise_en, input logic fall_en);
        return gpio_edge_e'({fall_en, rise_en});
    endfunction

    // One pin's event given its mode, the current and the previous sampled level.
    function automatic logic edge_event(input gpio_edge_e mode, input logic cur, input logic prev);
        logic ev;
        case (mode)
            EDGE_NONE: ev = 1'b0;
            EDGE_RISE: ev = cur & ~prev;
            EDGE_FALL: ev = ~cur & prev;
            EDGE_BOTH: ev = cur ^ prev;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/tmcu_gpio_sync.sv
// ----------------------------------------------------------------------------
// tmcu_gpio_sync
// WIDTH-wide, STAGES-deep flop chain bringing the asynchronous pad levels into
// the clk domain. All stages clear on synchronous active-high reset.
// Ports:
//   clk      in  1      system clock
//   rst      in  1      synchronous reset, active-high
//   pad_val  in  WIDTH  raw pad levels
//   sync_out out WIDTH  last synchroniser stage
// ----------------------------------------------------------------------------
module tmcu_gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_val,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the pad levels through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= pad_val;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign sync_out = stage_r[STAGES-1];

endmodule

// File: rtl/tmcu_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// tmcu_gpio_ctrl
// Parametrised GPIO controller: registered direction/drive onto bidirectional
// pads, synchronised readback of every pad (output pins read their own drive),
// per-pin rise/fall edge detection into sticky W1C status, masked interrupt.
// Optional build macro GPIO_DEBOUNCE_EN adds a per-pin stability filter of
// DEB_CYCLES clocks between the synchroniser and gpio_read.
// Ports:
//   clk         in    1      system clock
//   rst         in    1      synchronous reset, active-high
//   gpio_write  in    WIDTH  output data (registered before the pads)
//   gpio_dir    in    WIDTH  1 = input / pad high-Z, 0 = output (registered)
//   irq_rise_en in    WIDTH  rising edge sets status
//   irq_fall_en in    WIDTH  falling edge sets status
//   irq_mask    in    WIDTH  status bits that contribute to irq
//   irq_clr     in    WIDTH  write-1-to-clear pulse for status
//   gpio_read   out   WIDTH  synchronised (optionally debounced) pin levels
//   irq_status  out   WIDTH  sticky edge-event flags
//   irq         out   1      registered OR of (status & mask)
//   gpio_pins   inout WIDTH  bidirectional pads
// ----------------------------------------------------------------------------
module tmcu_gpio_ctrl
    import tmcu_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = GPIO_DEF_SYNC,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_write,
    input  logic [WIDTH-1:0] gpio_dir,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_read,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq,
    inout  wire  [WIDTH-1:0] gpio_pins
);

    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] read_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] status_r;
    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] next_status_s;
    logic             irq_r;

    // Direction and drive registers; reset releases every pad.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_r <= '1;
            out_r <= '0;
        end else begin
            dir_r <= gpio_dir;
            out_r <= gpio_write;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_pins[i] = dir_r[i] ? 1'bz : out_r[i];
    end

    tmcu_gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pad_val  (gpio_pins),
        .sync_out (sync_s)
    );

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] deb_cnt_r [WIDTH];
    logic [WIDTH-1:0] deb_r;

    // Accept a new level only after it has differed from the filtered value
    // for DEB_CYCLES consecutive clocks; any return to the old level restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_r[i]     <= sync_s[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    assign read_s = deb_r;
`else
    assign read_s = sync_s;
`endif

    // Edge events and next status; a fresh event overrides a clear on the same bit.
    always_comb begin
        ev_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ev_s[i] = edge_event(edge_mode(irq_rise_en[i], irq_fall_en[i]), read_s[i], prev_r[i]);
        end
        next_status_s = (status_r & ~irq_clr) | ev_s;
    end

    // Previous-level history, sticky status and the interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r   <= '0;
            status_r <= '0;
            irq_r    <= 1'b0;
        end else begin
            prev_r   <= read_s;
            status_r <= next_status_s;
            irq_r    <= |(next_status_s & irq_mask);
        end
    end

    assign gpio_read  = read_s;
    assign irq_status = status_r;
    assign irq        = irq_r;

endmodule

// File: tb/tb_tmcu_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tmcu_gpio_ctrl
// Directed bench for tmcu_gpio_ctrl (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=4).
// An external tri-state driver per pad models the outside world; it is only
// enabled on pins whose DUT direction register is input, so pads never fight.
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_tmcu_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
    localparam int DL = 4;
`else
    localparam int DL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio_write;
    logic [7:0] gpio_dir;
    logic [7:0] irq_rise_en;
    logic [7:0] irq_fall_en;
    logic [7:0] irq_mask;
    logic [7:0] irq_clr;
    logic [7:0] gpio_read;
    logic [7:0] irq_status;
    logic       irq;
    wire  [7:0] gpio_pins;

    logic [7:0] ext_en;
    logic [7:0] ext_val;

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 8; g++) begin : g_ext
        assign gpio_pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    always #5 clk = ~clk;

    tmcu_gpio_ctrl #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_write  (gpio_write),
        .gpio_dir    (gpio_dir),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_mask    (irq_mask),
        .irq_clr     (irq_clr),
        .gpio_read   (gpio_read),
        .irq_status  (irq_status),
        .irq         (irq),
        .gpio_pins   (gpio_pins)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        gpio_dir    = 8'h00;
        gpio_write  = 8'hFF;
        irq_rise_en = 8'h00;
        irq_fall_en = 8'h00;
        irq_mask    = 8'h00;
        irq_clr     = 8'h00;
        ext_en      = 8'hFF;
        ext_val     = 8'h3C;

        // Reset: pads released, so the external pattern is what the pads show.
        tick(3);
        chk("rst_pads_hiz", gpio_pins, 8'h3C);
        chk("rst_read", gpio_read, 8'h00);
        chk("rst_status", irq_status, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        rst    = 1'b0;
        ext_en = 8'h00;
        tick(1);
        chk("pads_after_rst", gpio_pins, 8'hFF);
        tick(2 + DL);
        chk("readback_ff", gpio_read, 8'hFF);

        // Loopback: lower nibble driven by the DUT (A5 -> 5), upper nibble input from outside (3).
        gpio_dir   = 8'hF0;
        gpio_write = 8'hA5;
        ext_val    = 8'h30;
        tick(1);
        ext_en = 8'hF0;
        tick(1);
        chk("loop_pads", gpio_pins, 8'h35);
        chk("loop_latency_hold", gpio_read, 8'hFF);
        tick(1 + DL);
        chk("loop_read", gpio_read, 8'h35);
        chk("no_enable_no_event", irq_status, 8'h00);

        // All pins to input, driven externally.
        gpio_dir = 8'hFF;
        ext_val  = 8'h34;
        tick(1);
        ext_en = 8'hFF;
        tick(2 + DL);
        chk("all_input_read", gpio_read, 8'h34);

        // Rising edge on pin0: status and irq exactly 3 cycles after the pad change.
        irq_rise_en = 8'h01;
        irq_mask    = 8'h01;
        tick(1);
        ext_val = 8'h35;
        tick(2 + DL);
        chk("rise_not_yet", irq_status, 8'h00);
        chk("rise_irq_not_yet", {7'd0, irq}, 8'h00);
        tick(1);
        chk("rise_status", irq_status, 8'h01);
        chk("rise_irq", {7'd0, irq}, 8'h01);
        irq_clr = 8'h01;
        tick(1);
        irq_clr = 8'h00;
        chk("w1c_status", irq_status, 8'h00);
        chk("w1c_irq", {7'd0, irq}, 8'h00);

        // Fall on masked pin2 sets status, no irq.
        irq_fall_en = 8'h04;
        ext_val     = 8'h31;
        tick(3 + DL);
        chk("masked_status", irq_status, 8'h04);
        chk("masked_irq", {7'd0, irq}, 8'h00);
        // Rise on pin2 is not enabled.
        ext_val = 8'h35;
        tick(2 + DL);
        chk("rise_disabled_read", gpio_read, 8'h35);
        chk("rise_disabled_status", irq_status, 8'h04);
        // New fall on pin2 on the same edge as its clear: set wins.
        ext_val = 8'h31;
        tick(2 + DL);
        irq_clr = 8'h04;
        tick(1);
        chk("set_wins", irq_status, 8'h04);
        // Clear bit2 together with already-zero bit3.
        irq_clr = 8'h0C;
        tick(1);
        irq_clr = 8'h00;
        chk("clear_with_zero_bit", irq_status, 8'h00);

        // Both edges on pin7: a 5-cycle high pulse.
        irq_rise_en = 8'h80;
        irq_fall_en = 8'h80;
        irq_mask    = 8'h80;
        ext_val     = 8'hB1;
        tick(3 + DL);
        chk("both_rise_status", irq_status, 8'h80);
        chk("both_rise_irq", {7'd0, irq}, 8'h01);
        irq_clr = 8'h80;
        tick(1);
        irq_clr = 8'h00;
        chk("both_cleared", irq_status, 8'h00);
        tick(1);
        ext_val = 8'h31;
        tick(2 + DL);
        chk("both_fall_not_yet", irq_status, 8'h00);
        tick(1);
        chk("both_fall_status", irq_status, 8'h80);
        chk("both_fall_irq", {7'd0, irq}, 8'h01);

        // Reset in the middle of pending edges discards everything.
        irq_rise_en = 8'hFF;
        irq_fall_en = 8'hFF;
        ext_val     = 8'h00;
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("midrst_status", irq_status, 8'h00);
        chk("midrst_read", gpio_read, 8'h00);
        chk("midrst_irq", {7'd0, irq}, 8'h00);
        rst = 1'b0;
        tick(4 + DL);
        chk("midrst_no_spurious", irq_status, 8'h00);
        chk("midrst_no_irq", {7'd0, irq}, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
        irq_rise_en = 8'h02;
        irq_fall_en = 8'h00;
        irq_mask    = 8'h02;
        // 3-cycle pulse on pin1 is filtered out.
        ext_val = 8'h02;
        tick(3);
        ext_val = 8'h00;
        tick(8);
        chk("deb_short_read", gpio_read, 8'h00);
        chk("deb_short_status", irq_status, 8'h00);
        // 6-cycle pulse: sync_out rises after 2 edges, gpio_read 4 edges later.
        ext_val = 8'h02;
        tick(5);
        chk("deb_long_early", gpio_read, 8'h00);
        tick(1);
        chk("deb_long_read", gpio_read, 8'h02);
        ext_val = 8'h00;
        tick(1);
        chk("deb_long_event", irq_status, 8'h02);
        irq_clr = 8'h02;
        tick(1);
        irq_clr = 8'h00;
        tick(8);
        chk("deb_long_settled", gpio_read, 8'h00);
        // Reset mid-count: the window restarts from zero after release.
        ext_val = 8'h02;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("deb_rst_count_cleared", gpio_read, 8'h00);
        chk("deb_rst_no_event", irq_status, 8'h00);
        tick(1);
        chk("deb_rst_full_window", gpio_read, 8'h02);
        ext_val = 8'h00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
